// File: rtl/free_preg_ctrl.sv
// rtl/free_preg_ctrl.sv - free physical-register queue controller and write-port arbiter
//
// Purpose:
//   Seeds the external free-preg queue after reset with every preg that is not
//   part of the reset architectural mapping. After seeding, it arbitrates the
//   queue's single write port between commit releases and squash-recovery
//   releases. It grants rename allocations from the queue head and tracks how
//   many entries the queue holds.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   alloc_req/alloc_gnt/alloc_preg   rename allocation (zero-latency grant from queue head)
//   rel_valid/rel_preg/rel_ready     commit-time release handshake
//   sq_start                     pulse that enters squash recovery
//   sq_valid/sq_preg/sq_last/sq_ready squash release stream
//   fq_w_en/fq_preg_in           queue write port
//   fq_r_en/fq_preg_out          queue pop and combinational head
//   fq_full/fq_empty             queue status
//   init_done, recovering        state indications
//   free_count                   number of entries currently in the queue

module free_preg_ctrl #(
    parameter int NUM_PREGS = 128,
    parameter int NUM_AREGS = 32,
    parameter int PREG_W    = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output logic [PREG_W-1:0] alloc_preg,
    input  logic              rel_valid,
    input  logic [PREG_W-1:0] rel_preg,
    output logic              rel_ready,
    input  logic              sq_start,
    input  logic              sq_valid,
    input  logic [PREG_W-1:0] sq_preg,
    input  logic              sq_last,
    output logic              sq_ready,
    output logic              fq_w_en,
    output logic [PREG_W-1:0] fq_preg_in,
    output logic              fq_r_en,
    input  logic [PREG_W-1:0] fq_preg_out,
    input  logic              fq_full,
    input  logic              fq_empty,
    output logic              init_done,
    output logic              recovering,
    output logic [PREG_W:0]   free_count
);

    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    localparam logic [PREG_W-1:0] SEED_FIRST = PREG_W'(NUM_AREGS);
    localparam logic [PREG_W-1:0] SEED_LAST  = PREG_W'(NUM_PREGS - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [PREG_W-1:0] seed_cnt;
    logic              rel_acc;
    logic              sq_acc;

    always_comb begin
        state_nxt  = state;
        alloc_gnt  = 1'b0;
        rel_ready  = 1'b0;
        sq_ready   = 1'b0;
        rel_acc    = 1'b0;
        sq_acc     = 1'b0;
        fq_w_en    = 1'b0;
        fq_preg_in = '0;
        case (state)
            ST_INIT: begin
                // Gated by rst_n so nothing is pushed while the queue is held in reset.
                fq_w_en    = rst_n;
                fq_preg_in = seed_cnt;
                if (seed_cnt == SEED_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // sq_start blocks the grant so no preg leaves the queue on the
                // cycle the pipeline begins unwinding.
                alloc_gnt  = alloc_req & ~fq_empty & ~sq_start;
                rel_ready  = ~fq_full;
                rel_acc    = rel_valid & rel_ready;
                fq_w_en    = rel_acc;
                fq_preg_in = rel_preg;
                if (sq_start) begin
                    state_nxt = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                sq_ready   = ~fq_full;
                sq_acc     = sq_valid & sq_ready;
                fq_w_en    = sq_acc;
                fq_preg_in = sq_preg;
                if (sq_acc && sq_last) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    assign fq_r_en    = alloc_gnt;
    // A released preg only reaches the tail, so the grant always returns the head.
    assign alloc_preg = fq_preg_out;
    assign init_done  = (state != ST_INIT);
    assign recovering = (state == ST_RECOVER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            seed_cnt   <= SEED_FIRST;
            free_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                seed_cnt <= seed_cnt + PREG_W'(1);
            end
            case ({fq_w_en, fq_r_en})
                2'b10:   free_count <= free_count + (PREG_W+1)'(1);
                2'b01:   free_count <= free_count - (PREG_W+1)'(1);
                default: free_count <= free_count;
            endcase
        end
    end

endmodule

// File: tb/tb_free_preg_ctrl.sv
// tb/tb_free_preg_ctrl.sv - self-checking bench for free_preg_ctrl with a queue-level model
module tb_free_preg_ctrl;

    localparam int NP = 128;
    localparam int NA = 32;
    localparam int W  = 7;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         alloc_req;
    logic         alloc_gnt;
    logic [W-1:0] alloc_preg;
    logic         rel_valid;
    logic [W-1:0] rel_preg;
    logic         rel_ready;
    logic         sq_start;
    logic         sq_valid;
    logic [W-1:0] sq_preg;
    logic         sq_last;
    logic         sq_ready;
    logic         fq_w_en;
    logic [W-1:0] fq_preg_in;
    logic         fq_r_en;
    logic [W-1:0] fq_preg_out;
    logic         fq_full;
    logic         fq_empty;
    logic         init_done;
    logic         recovering;
    logic [W:0]   free_count;

    always #5 clk = ~clk;

    free_preg_ctrl #(.NUM_PREGS(NP), .NUM_AREGS(NA), .PREG_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_preg(alloc_preg),
        .rel_valid(rel_valid), .rel_preg(rel_preg), .rel_ready(rel_ready),
        .sq_start(sq_start), .sq_valid(sq_valid), .sq_preg(sq_preg),
        .sq_last(sq_last), .sq_ready(sq_ready),
        .fq_w_en(fq_w_en), .fq_preg_in(fq_preg_in), .fq_r_en(fq_r_en),
        .fq_preg_out(fq_preg_out), .fq_full(fq_full), .fq_empty(fq_empty),
        .init_done(init_done), .recovering(recovering), .free_count(free_count)
    );

    typedef enum int {M_INIT, M_RUN, M_REC} mode_t;

    int           n_total = 0;
    int           n_pass  = 0;
    logic [W-1:0] fifo[$];
    mode_t        mode;
    int           seed_next;
    logic         s_w, s_r, s_gnt, s_rel_ready;
    logic [W-1:0] s_wdata, s_preg;
    logic         e_sq_acc;
    int           w_cnt;
    int           first_w;
    int           rec_cnt;
    int           fc0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic refresh_fifo();
        fq_empty    = (fifo.size() == 0);
        fq_full     = (fifo.size() >= NP);
        fq_preg_out = (fifo.size() > 0) ? fifo[0] : '0;
    endtask

    task automatic set_in(input int areq, input int rv, input int rp,
                          input int ss, input int sv, input int sp, input int sl);
        alloc_req = areq[0];
        rel_valid = rv[0];
        rel_preg  = W'(rp);
        sq_start  = ss[0];
        sq_valid  = sv[0];
        sq_preg   = W'(sp);
        sq_last   = sl[0];
    endtask

    // Expected outputs follow directly from the mode and the queue occupancy.
    task automatic compare();
        int sz = fifo.size();
        int e_gnt = 0, e_rr = 0, e_sr = 0, e_w = 0, e_wd = 0, e_done = 0, e_rec = 0;
        if (rst_n) begin
            case (mode)
                M_INIT: begin
                    e_w  = 1;
                    e_wd = seed_next;
                end
                M_RUN: begin
                    e_done = 1;
                    e_gnt  = int'(alloc_req && sz > 0 && !sq_start);
                    e_rr   = int'(sz < NP);
                    e_w    = int'(rel_valid && e_rr != 0);
                    e_wd   = int'(rel_preg);
                end
                default: begin
                    e_done = 1;
                    e_rec  = 1;
                    e_sr   = int'(sz < NP);
                    e_w    = int'(sq_valid && e_sr != 0);
                    e_wd   = int'(sq_preg);
                end
            endcase
        end
        chk("alloc_gnt", int'(alloc_gnt), e_gnt);
        chk("fq_r_en", int'(fq_r_en), e_gnt);
        if (e_gnt != 0) chk("alloc_preg", int'(alloc_preg), int'(fifo[0]));
        chk("rel_ready", int'(rel_ready), e_rr);
        chk("sq_ready", int'(sq_ready), e_sr);
        chk("fq_w_en", int'(fq_w_en), e_w);
        if (e_w != 0) chk("fq_preg_in", int'(fq_preg_in), e_wd);
        chk("init_done", int'(init_done), e_done);
        chk("recovering", int'(recovering), e_rec);
        chk("free_count", int'(free_count), sz);
        chk("write_while_full", int'(fq_w_en && fq_full), 0);
        chk("pop_while_empty", int'(fq_r_en && fq_empty), 0);
        e_sq_acc    = (rst_n && mode == M_REC && sq_valid && e_sr != 0);
        s_w         = fq_w_en;
        s_wdata     = fq_preg_in;
        s_r         = fq_r_en;
        s_gnt       = alloc_gnt;
        s_preg      = alloc_preg;
        s_rel_ready = rel_ready;
        if (fq_w_en) begin
            w_cnt++;
            if (first_w < 0) first_w = int'(fq_preg_in);
        end
        if (recovering) rec_cnt++;
    endtask

    task automatic update();
        if (!rst_n) begin
            fifo.delete();
            mode      = M_INIT;
            seed_next = NA;
        end else begin
            if (s_r && fifo.size() > 0) void'(fifo.pop_front());
            if (s_w && fifo.size() < NP) fifo.push_back(s_wdata);
            case (mode)
                M_INIT: begin
                    if (seed_next == NP - 1) mode = M_RUN;
                    seed_next++;
                end
                M_RUN:   if (sq_start) mode = M_REC;
                default: if (e_sq_acc && sq_last) mode = M_RUN;
            endcase
        end
        refresh_fifo();
    endtask

    // One clock: check at the falling edge, advance the queue after the rising edge.
    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        update();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        fifo.delete();
        mode      = M_INIT;
        seed_next = NA;
        refresh_fifo();
        #1;
        chk("rst_recovering", int'(recovering), 0);
        chk("rst_alloc_gnt", int'(alloc_gnt), 0);
        chk("rst_free_count", int'(free_count), 0);
        chk("rst_init_done", int'(init_done), 0);
    endtask

    task automatic seed_phase();
        rst_n   = 1'b1;
        w_cnt   = 0;
        first_w = -1;
        repeat (NP - NA) cycle();
        chk("seed_first", first_w, NA);
        chk("init_done_rise", int'(init_done), 1);
        chk("free_after_seed", int'(free_count), NP - NA);
        cycle();
        chk("seed_cycles", w_cnt, NP - NA);
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = M_INIT;
        seed_next = NA;
        w_cnt     = 0;
        first_w   = -1;
        rec_cnt   = 0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        refresh_fifo();
        repeat (3) cycle();
        seed_phase();

        // Drain the whole queue, then one allocation against an empty queue.
        set_in(1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("first_alloc_gnt", int'(s_gnt), 1);
        chk("first_alloc_preg", int'(s_preg), 32);
        chk("free_95", int'(free_count), 95);
        repeat (95) cycle();
        chk("last_alloc_preg", int'(s_preg), 127);
        chk("free_drained", int'(free_count), 0);
        cycle();
        chk("alloc_when_empty", int'(s_gnt), 0);
        chk("no_pop_when_empty", int'(s_r), 0);

        // Build 10 entries, then allocate and release together.
        for (int i = 0; i < 10; i++) begin
            set_in(0, 1, 50 + i, 0, 0, 0, 0);
            cycle();
        end
        chk("free_10", int'(free_count), 10);
        set_in(1, 1, 5, 0, 0, 0, 0);
        cycle();
        chk("both_gnt", int'(s_gnt), 1);
        chk("both_rel_ready", int'(s_rel_ready), 1);
        chk("both_preg", int'(s_preg), 50);
        chk("both_free_10", int'(free_count), 10);
        set_in(1, 0, 0, 0, 0, 0, 0);
        repeat (10) cycle();
        chk("released_after_older", int'(s_preg), 5);

        // Squash recovery with allocation and release held high.
        for (int i = 0; i < 5; i++) begin
            set_in(0, 1, 60 + i, 0, 0, 0, 0);
            cycle();
        end
        set_in(1, 1, 70, 1, 0, 0, 0);
        cycle();
        chk("sq_start_no_gnt", int'(s_gnt), 0);
        chk("sq_start_rel_ok", int'(s_rel_ready), 1);
        chk("sq_start_free", int'(free_count), 6);
        rec_cnt = 0;
        fc0     = int'(free_count);
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 70, 0, 1, 40 + i, int'(i == 2));
            cycle();
        end
        chk("recover_cycles", rec_cnt, 3);
        chk("recover_free_plus3", int'(free_count), fc0 + 3);
        set_in(1, 1, 70, 0, 0, 0, 0);
        cycle();
        chk("post_recover_gnt", int'(s_gnt), 1);
        chk("post_recover_free", int'(free_count), fc0 + 3);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            set_in(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, NP - 1)), int'($urandom_range(0, 15) == 0),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, NP - 1)),
                   int'($urandom_range(0, 3) == 0));
            cycle();
        end

        // Fill to full by releasing the architectural pregs.
        set_in(0, 0, 0, 0, 0, 0, 0);
        apply_reset();
        cycle();
        seed_phase();
        for (int i = 0; i < NA; i++) begin
            set_in(0, 1, i, 0, 0, 0, 0);
            cycle();
        end
        chk("free_full", int'(free_count), NP);
        set_in(0, 1, 0, 0, 0, 0, 0);
        repeat (2) cycle();
        chk("full_rel_blocked", int'(s_rel_ready), 0);
        set_in(1, 1, 0, 0, 0, 0, 0);
        cycle();
        chk("full_alloc_gnt", int'(s_gnt), 1);
        chk("full_rel_still_blocked", int'(s_rel_ready), 0);
        set_in(0, 1, 0, 0, 0, 0, 0);
        cycle();
        chk("rel_after_alloc", int'(s_rel_ready), 1);
        chk("free_back_full", int'(free_count), NP);

        // Reset in the middle of a recovery.
        set_in(0, 0, 0, 1, 0, 0, 0);
        cycle();
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 0, 0, 1, 40 + i, 0);
            cycle();
        end
        chk("mid_recover", int'(recovering), 1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        apply_reset();
        repeat (2) cycle();
        seed_phase();
        set_in(1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("reseed_first_alloc", int'(s_preg), 32);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
